// File: rtl/display_mode_controller.sv
// Display mode FSM: selects time or volume view, with hold timeout, lock and pause blink.
// Latency: all outputs registered; a sampled input shows up one clk after the edge.
// Backpressure: none; event pulses are consumed on the edge they are sampled.
module display_mode_controller #(
   parameter int unsigned HOLD_TICKS  = 20,
   parameter int unsigned BLINK_TICKS = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       volume_event,
   input  logic       lock_toggle,
   input  logic       paused,
   output logic       select,
   output logic       blank,
   output logic [1:0] mode
);

   localparam logic [1:0] ST_TIME = 2'b00;
   localparam logic [1:0] ST_HOLD = 2'b01;
   localparam logic [1:0] ST_LOCK = 2'b10;

   localparam logic [7:0] HOLD_LOAD  = HOLD_TICKS[7:0];
   localparam logic [7:0] BLINK_LAST = BLINK_TICKS[7:0];

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [7:0] hold_cnt;
   logic [7:0] hold_nxt;
   logic [7:0] blink_cnt;
   logic [7:0] blink_nxt;
   logic       blank_nxt;

   // Next state and hold counter; lock_toggle outranks volume_event, reload outranks tick.
   always_comb begin
      state_nxt = ST_TIME;
      hold_nxt  = 8'd0;
      case (state)
         ST_TIME: begin
            if (lock_toggle) begin
               state_nxt = ST_LOCK;
            end else if (volume_event) begin
               state_nxt = ST_HOLD;
               hold_nxt  = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (lock_toggle) begin
               state_nxt = ST_LOCK;
            end else if (volume_event) begin
               state_nxt = ST_HOLD;
               hold_nxt  = HOLD_LOAD;
            end else if (tick) begin
               // Last tick of the hold returns to time view on the same edge.
               if (hold_cnt <= 8'd1) begin
                  state_nxt = ST_TIME;
                  hold_nxt  = 8'd0;
               end else begin
                  state_nxt = ST_HOLD;
                  hold_nxt  = hold_cnt - 8'd1;
               end
            end else begin
               state_nxt = ST_HOLD;
               hold_nxt  = hold_cnt;
            end
         end
         ST_LOCK: begin
            state_nxt = lock_toggle ? ST_TIME : ST_LOCK;
         end
         default: begin
            // Illegal encoding falls back to time view.
            state_nxt = ST_TIME;
         end
      endcase
   end

   // Blink phase advances only while paused and staying in time view; otherwise it restarts.
   always_comb begin
      blink_nxt = 8'd0;
      blank_nxt = 1'b0;
      if (paused && (state == ST_TIME) && (state_nxt == ST_TIME)) begin
         blink_nxt = blink_cnt;
         blank_nxt = blank;
         if (tick) begin
            if ((blink_cnt + 8'd1) >= BLINK_LAST) begin
               blink_nxt = 8'd0;
               blank_nxt = ~blank;
            end else begin
               blink_nxt = blink_cnt + 8'd1;
            end
         end
      end
   end

   // State and output registers with asynchronous clear to time view.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_TIME;
         hold_cnt  <= 8'd0;
         blink_cnt <= 8'd0;
         blank     <= 1'b0;
         select    <= 1'b0;
         mode      <= ST_TIME;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         blink_cnt <= blink_nxt;
         blank     <= blank_nxt;
         select    <= (state_nxt != ST_TIME);
         mode      <= state_nxt;
      end
   end

endmodule
